// File: rtl/buffer_escrita_principal.sv
// Write-back buffer and main-memory controller below the L2.
// Evictions queue in a small FIFO; fill reads forward from it or hit memory.
module buffer_escrita_principal #(
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [5:0]  wb_address,
    input  logic [15:0] wb_data,
    output logic        wb_ready,
    input  logic        rd_req,
    input  logic [5:0]  rd_address,
    output logic        rd_busy,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        rd_from_buffer,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(MEM_LAT) + 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LAT - 1);

    typedef enum logic {
        D_IDLE,
        D_WRITE
    } dstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FWD,
        R_WAIT,
        R_MEM
    } rstate_t;

    logic [5:0]    fa_q [DEPTH];
    logic [15:0]   fd_q [DEPTH];
    // Stored as data^address so the power-up zero state reads as mem[i]=i.
    bit   [15:0]   mem_q [64];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;

    dstate_t       dstate_q, dstate_d;
    logic [LW-1:0] dcnt_q, dcnt_d;

    rstate_t       rstate_q, rstate_d;
    logic [LW-1:0] rcnt_q, rcnt_d;
    logic [5:0]    raddr_q, raddr_d;
    logic [15:0]   fwd_q, fwd_d;
    logic          valid_q, valid_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          fb_q, fb_d;

    logic          push;
    logic          commit;
    logic          rd_start;
    logic          hit;
    logic [15:0]   hit_data;

    assign wb_ready       = cnt_q < CW'(DEPTH);
    assign empty          = cnt_q == '0;
    assign rd_busy        = rstate_q != R_IDLE;
    assign rd_valid       = valid_q;
    assign rd_data        = rdata_q;
    assign rd_from_buffer = fb_q;

    assign push     = wb_valid && wb_ready;
    assign commit   = (dstate_q == D_WRITE) && (dcnt_q == LAT_LAST);
    assign rd_start = (rstate_q == R_IDLE) && rd_req;

    // Oldest to youngest scan; the last hit wins, the incoming push last of all.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < cnt_q &&
                fa_q[head_q + PW'(k)] == rd_address) begin
                hit      = 1'b1;
                hit_data = fd_q[head_q + PW'(k)];
            end
        end
        if (push && wb_address == rd_address) begin
            hit      = 1'b1;
            hit_data = wb_data;
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (commit) begin
            head_d = head_q + 1'b1;
        end
        case ({push, commit})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        dstate_d = dstate_q;
        dcnt_d   = dcnt_q;
        unique case (dstate_q)
            D_IDLE: begin
                if (cnt_q != '0 && rstate_q != R_MEM && !rd_start) begin
                    dstate_d = D_WRITE;
                    dcnt_d   = '0;
                end
            end
            D_WRITE: begin
                if (commit) begin
                    dstate_d = D_IDLE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: dstate_d = D_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rcnt_d   = rcnt_q;
        raddr_d  = raddr_q;
        fwd_d    = fwd_q;
        valid_d  = 1'b0;
        rdata_d  = rdata_q;
        fb_d     = fb_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (rd_req) begin
                    raddr_d = rd_address;
                    rcnt_d  = '0;
                    if (hit) begin
                        fwd_d    = hit_data;
                        rstate_d = R_FWD;
                    end else if (dstate_q == D_WRITE && !commit) begin
                        rstate_d = R_WAIT;
                    end else begin
                        rstate_d = R_MEM;
                    end
                end
            end
            R_FWD: begin
                valid_d  = 1'b1;
                rdata_d  = fwd_q;
                fb_d     = 1'b1;
                rstate_d = R_IDLE;
            end
            R_WAIT: begin
                if (commit) begin
                    rcnt_d   = '0;
                    rstate_d = R_MEM;
                end
            end
            R_MEM: begin
                if (rcnt_q == LAT_LAST) begin
                    valid_d  = 1'b1;
                    rdata_d  = mem_q[raddr_q] ^ {10'd0, raddr_q};
                    fb_d     = 1'b0;
                    rstate_d = R_IDLE;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            dstate_q <= D_IDLE;
            dcnt_q   <= '0;
            rstate_q <= R_IDLE;
            rcnt_q   <= '0;
            raddr_q  <= '0;
            fwd_q    <= '0;
            valid_q  <= 1'b0;
            rdata_q  <= '0;
            fb_q     <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            dstate_q <= dstate_d;
            dcnt_q   <= dcnt_d;
            rstate_q <= rstate_d;
            rcnt_q   <= rcnt_d;
            raddr_q  <= raddr_d;
            fwd_q    <= fwd_d;
            valid_q  <= valid_d;
            rdata_q  <= rdata_d;
            fb_q     <= fb_d;
        end
    end

    // Storage has no reset; commit is already gated by the drain state.
    always_ff @(posedge clock) begin
        if (push) begin
            fa_q[tail_q] <= wb_address;
            fd_q[tail_q] <= wb_data;
        end
        if (commit) begin
            mem_q[fa_q[head_q]] <= fd_q[head_q] ^ {10'd0, fa_q[head_q]};
        end
    end

endmodule
